turf_rdwr_decoder: RTL
======================

Name: turf_rdwr_decoder

Overview:
- Sits directly downstream of the stream-to-rdwr bridge and consumes its generic rdwr bus (en/wr/ack/adr/dat).
- Decodes the top address bits to one of NUM_TARGETS register targets and forwards the transaction with a registered, per-target enable.
- Returns the target's ack/read data upstream.
- Unmapped accesses and non-responding targets are answered with a fixed error word, so the upstream bridge can never hang.

Parameters:
NUM_TARGETS, 4, number of downstream targets (1..16).
TARGET_ADR_BITS, 24, low address bits passed to targets; select index = adr_i[27:TARGET_ADR_BITS].
TIMEOUT_CYCLES, 255, max cycles in ACCESS before forced completion (>=2, fits 16 bits).
ERROR_DATA, 32'hDEADBEEF, read data returned on unmapped access or timeout.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
en_i  in  1  upstream request; held until ack_o
wr_i  in  1  upstream write select, valid with en_i
adr_i  in  28  upstream address
dat_i  in  32  upstream write data
ack_o  out  1  upstream completion, one-cycle pulse
dat_o  out  32  upstream read data, valid with ack_o, held afterwards
m_en_o  out  NUM_TARGETS  one-hot target enable
m_wr_o  out  1  target write select
m_adr_o  out  TARGET_ADR_BITS  target address
m_dat_o  out  32  target write data
m_ack_i  in  NUM_TARGETS  per-target ack
m_dat_i  in  32*NUM_TARGETS  per-target read data; target n at [32n +: 32]

Behaviour:
- Reset (async, aresetn low): state=IDLE, timeout counter=0. ack_o, dat_o, m_en_o, m_wr_o, m_adr_o, m_dat_o all 0. Reset mid-access drops m_en_o immediately; no ack_o is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, ERROR, RESPOND.
- IDLE, en_i=1:
  - Latch wr_i, adr_i[TARGET_ADR_BITS-1:0], dat_i and sel = adr_i[27:TARGET_ADR_BITS].
  - If sel < NUM_TARGETS: go to ACCESS, set m_en_o = 1<<sel, counter=0.
  - Else: go to ERROR.
- ACCESS:
  - m_en_o, m_wr_o, m_adr_o and m_dat_o are stable. Counter increments each cycle.
  - m_ack_i[sel]=1: capture m_dat_i[sel] into dat_o if read; dat_o unchanged if write. Clear m_en_o, assert ack_o, go to RESPOND.
  - Else if counter == TIMEOUT_CYCLES-1: clear m_en_o, dat_o=ERROR_DATA if read, assert ack_o, go to RESPOND.
  - Ack and timeout in the same cycle: the ack wins.
  - m_ack_i bits from non-selected targets are ignored at all times.
- ERROR: one cycle, no m_en_o. dat_o=ERROR_DATA if read. Assert ack_o, go to RESPOND.
- RESPOND: ack_o high for exactly this cycle, then cleared. Go to IDLE. en_i is ignored in RESPOND, because upstream drops it after seeing ack.
- Latency:
  - en_i sampled at cycle 0 → m_en_o high at cycle 1.
  - Zero-wait target acks at cycle 1 → ack_o at cycle 2.
  - Unmapped access → ack_o at cycle 2.
  - Timeout → ack_o at cycle TIMEOUT_CYCLES+1.
- Late ack from a timed-out target (m_en_o already low) is ignored.
- At most one transaction is outstanding. m_en_o is never multi-hot.
- dat_o holds its last value between responses. m_adr_o, m_dat_o and m_wr_o hold their last latched values after completion.

Optional Feature:
Macro TURF_RDWR_DECODER_ERRSTAT_EN.
- Defined:
  - Adds output err_count_o [15:0]: saturating count of unmapped and timed-out accesses; sticks at 16'hFFFF.
  - Adds output err_adr_o [27:0]: full address of the most recent error.
  - Adds input err_clr_i: clears err_count_o synchronously; if it coincides with an error, count becomes 1.
  - Reset values are 0.
- Undefined: these ports do not exist and no error logic is built. The rest of the behaviour is identical.

Test Plan:
- Read adr 0x1000010, target1 acks with 0x12345678 on its first m_en cycle → m_en_o=4'b0010, m_adr_o=0x000010, ack_o at cycle 2, dat_o=0x12345678.
- Write adr 0x3000004, dat 0xCAFEF00D, target3 acks after 5 wait cycles → m_wr_o=1, m_dat_o=0xCAFEF00D stable throughout, single ack_o pulse, dat_o unchanged.
- Read adr 0x7000000 (unmapped, NUM_TARGETS=4) → no m_en_o, ack_o at cycle 2, dat_o=0xDEADBEEF; with ERRSTAT, err_count_o=1 and err_adr_o=0x7000000.
- Read target0, never acked, TIMEOUT_CYCLES=255 → m_en_o drops and ack_o asserts at cycle 256, dat_o=0xDEADBEEF. A target0 ack injected 3 cycles later produces no ack_o.
- Target2 acks while target1 is selected, and target1 acks on the terminal timeout cycle → ack from target2 ignored, dat_o=target1 data (ack wins).
- aresetn low during ACCESS → m_en_o=0 asynchronously, no ack_o. After release, a new read of target0 completes normally.

Source files
------------

// File: rtl/turf_rdwr_decoder.sv
// turf_rdwr_decoder: address-decodes an rdwr request onto one of NUM_TARGETS targets with timeout/unmapped error replies.
// Optional error statistics ports are built when TURF_RDWR_DECODER_ERRSTAT_EN is defined.
module turf_rdwr_decoder #(
  parameter int          NUM_TARGETS     = 4,
  parameter int          TARGET_ADR_BITS = 24,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] ERROR_DATA      = 32'hDEADBEEF
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       en_i,
  input  logic                       wr_i,
  input  logic [27:0]                adr_i,
  input  logic [31:0]                dat_i,
  output logic                       ack_o,
  output logic [31:0]                dat_o,
  output logic [NUM_TARGETS-1:0]     m_en_o,
  output logic                       m_wr_o,
  output logic [TARGET_ADR_BITS-1:0] m_adr_o,
  output logic [31:0]                m_dat_o,
  input  logic [NUM_TARGETS-1:0]     m_ack_i,
  input  logic [32*NUM_TARGETS-1:0]  m_dat_i
`ifdef TURF_RDWR_DECODER_ERRSTAT_EN
  ,
  output logic [15:0]                err_count_o,
  output logic [27:0]                err_adr_o,
  input  logic                       err_clr_i
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESPOND} state_t;
  state_t                     state_q, state_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       ack_q, ack_d;
  logic [31:0]                dat_q, dat_d;
  logic [NUM_TARGETS-1:0]     m_en_q, m_en_d;
  logic                       m_wr_q, m_wr_d;
  logic [TARGET_ADR_BITS-1:0] m_adr_q, m_adr_d;
  logic [31:0]                m_dat_q, m_dat_d;
  logic [31:0]                sel_w, rd_dat;
  logic                       tgt_ack, timeout;
  // m_en_q is one-hot on the selected target, so masking with it ignores every other target's ack.
  always_comb begin
    sel_w   = 32'(adr_i[27:TARGET_ADR_BITS]);
    tgt_ack = |(m_ack_i & m_en_q);
    timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    rd_dat  = '0;
    for (int n = 0; n < NUM_TARGETS; n++) if (m_en_q[n]) rd_dat = m_dat_i[32*n +: 32];
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    m_en_d  = m_en_q;
    m_wr_d  = m_wr_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    case (state_q)
      IDLE: if (en_i) begin
        m_wr_d  = wr_i;
        m_adr_d = adr_i[TARGET_ADR_BITS-1:0];
        m_dat_d = dat_i;
        cnt_d   = '0;
        state_d = sel_w < NUM_TARGETS ? ACCESS : ERROR;
        for (int n = 0; n < NUM_TARGETS; n++) m_en_d[n] = sel_w == n;
      end
      ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        if (tgt_ack || timeout) begin
          m_en_d  = '0;
          ack_d   = 1'b1;
          dat_d   = m_wr_q ? dat_q : tgt_ack ? rd_dat : ERROR_DATA;
          state_d = RESPOND;
        end
      end
      ERROR: begin
        ack_d   = 1'b1;
        dat_d   = m_wr_q ? dat_q : ERROR_DATA;
        state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      m_en_q  <= '0;
      m_wr_q  <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      m_en_q  <= m_en_d;
      m_wr_q  <= m_wr_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
    end
  end
  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign m_en_o  = m_en_q;
  assign m_wr_o  = m_wr_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
`ifdef TURF_RDWR_DECODER_ERRSTAT_EN
  logic [27:TARGET_ADR_BITS] adr_hi_q, adr_hi_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic [27:0]               err_adr_q, err_adr_d;
  logic                      err;
  always_comb begin
    err       = state_q == ERROR || (state_q == ACCESS && !tgt_ack && timeout);
    adr_hi_d  = (state_q == IDLE && en_i) ? adr_i[27:TARGET_ADR_BITS] : adr_hi_q;
    err_cnt_d = err_clr_i ? {15'd0, err} : (err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    err_adr_d = err ? {adr_hi_q, m_adr_q} : err_adr_q;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      adr_hi_q  <= '0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else begin
      adr_hi_q  <= adr_hi_d;
      err_cnt_q <= err_cnt_d;
      err_adr_q <= err_adr_d;
    end
  end
  assign err_count_o = err_cnt_q;
  assign err_adr_o   = err_adr_q;
`endif
endmodule
